// File: rtl/dsi_link_sched.sv
// rtl/dsi_link_sched.sv - DSI lane power-state scheduler for HS bursts
//
// Sequences the clock lane and data lanes in and out of HS mode around each
// burst from the packet source, and enforces a minimum LP gap between bursts.
// Every lane handshake wait is bounded; on expiry the block parks in ERR.
//
// Ports
//   byte_clk, byte_rst         : clock, async active-high reset
//   in_data/in_valid/in_last   : payload stream from the packet source
//   in_ready                   : payload accept (STREAM only, combinational)
//   cl_hs_req/cl_hs_rdy/cl_idle: clock lane HS handshake and LP11 status
//   cl_enable                  : clock toggling enable
//   dl_hs_req/dl_hs_rdy/dl_idle: data lanes HS handshake and LP11 status
//   out_data/out_valid         : words to the data-lane serializers
//   busy, err, err_clr         : status, sticky timeout flag, its clear
//   burst_cnt                  : completed bursts, wraps at 2^16
module dsi_link_sched #(
  parameter int unsigned LP_GAP  = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        byte_clk,
  input  logic        byte_rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        cl_hs_req,
  input  logic        cl_hs_rdy,
  input  logic        cl_idle,
  output logic        cl_enable,
  output logic        dl_hs_req,
  input  logic        dl_hs_rdy,
  input  logic        dl_idle,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] burst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLK_UP,
    S_DATA_UP,
    S_STREAM,
    S_DATA_DOWN,
    S_CLK_DOWN,
    S_GAP,
    S_ERR
  } state_t;

  localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);
  localparam logic [7:0]  GAP_LAST    = 8'(LP_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic        cl_hs_req_q, cl_hs_req_d;
  logic        dl_hs_req_q, dl_hs_req_d;
  logic        cl_enable_q, cl_enable_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        timed_out;
  logic        waiting;

  // State and registered-output flops
  always_ff @(posedge byte_clk or posedge byte_rst) begin
    if (byte_rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
      cl_hs_req_q <= 1'b0;
      dl_hs_req_q <= 1'b0;
      cl_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cl_hs_req_q <= cl_hs_req_d;
      dl_hs_req_q <= dl_hs_req_d;
      cl_enable_q <= cl_enable_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next state and counters. Handshakes are tested before the timeout so a
  // response landing on the final wait cycle still wins.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    timed_out   = (wait_cnt_q == TIMEOUT_W);
    waiting     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_CLK_UP;
      end
      S_CLK_UP: begin
        waiting = 1'b1;
        if (cl_hs_rdy)      state_d = S_DATA_UP;
        else if (timed_out) state_d = S_ERR;
      end
      S_DATA_UP: begin
        waiting = 1'b1;
        if (dl_hs_rdy)      state_d = S_STREAM;
        else if (timed_out) state_d = S_ERR;
      end
      S_STREAM: begin
        // in_ready is 1 throughout STREAM, so in_valid alone is a transfer
        if (in_valid && in_last) state_d = S_DATA_DOWN;
      end
      S_DATA_DOWN: begin
        waiting = 1'b1;
        if (dl_idle)        state_d = S_CLK_DOWN;
        else if (timed_out) state_d = S_ERR;
      end
      S_CLK_DOWN: begin
        waiting = 1'b1;
        if (cl_idle) begin
          state_d     = S_GAP;
          burst_cnt_d = burst_cnt_q + 16'd1;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      S_ERR: begin
        if (err_clr && cl_idle && dl_idle) state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase

    // Both counters restart on any state entry
    if (state_d != state_q) begin
      wait_cnt_d = '0;
      gap_cnt_d  = '0;
    end else begin
      wait_cnt_d = waiting ? wait_cnt_q + 16'd1 : wait_cnt_q;
      gap_cnt_d  = (state_q == S_GAP) ? gap_cnt_q + 8'd1 : gap_cnt_q;
    end
  end

  // Registered outputs are decoded from the next state so they change on
  // the same edge as the state they belong to.
  always_comb begin
    cl_hs_req_d = 1'b0;
    dl_hs_req_d = 1'b0;
    cl_enable_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    err_d       = (state_d == S_ERR);
    case (state_d)
      S_CLK_UP: begin
        cl_hs_req_d = 1'b1;
      end
      S_DATA_UP: begin
        cl_hs_req_d = 1'b1;
        dl_hs_req_d = 1'b1;
      end
      S_STREAM: begin
        cl_hs_req_d = 1'b1;
        dl_hs_req_d = 1'b1;
        cl_enable_d = 1'b1;
      end
      S_DATA_DOWN: begin
        // Clock keeps running until the data lanes have settled in LP11
        cl_hs_req_d = 1'b1;
        cl_enable_d = 1'b1;
      end
      default: begin
        cl_hs_req_d = 1'b0;
      end
    endcase
  end

  // Zero-latency pass-through while streaming
  assign in_ready  = (state_q == S_STREAM);
  assign out_valid = in_ready & in_valid;
  assign out_data  = in_ready ? in_data : 32'd0;

  assign cl_hs_req = cl_hs_req_q;
  assign dl_hs_req = dl_hs_req_q;
  assign cl_enable = cl_enable_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_dsi_link_sched.sv
// tb/tb_dsi_link_sched.sv - self-checking bench for dsi_link_sched
module tb_dsi_link_sched;
  localparam int LP_GAP  = 8;
  localparam int TIMEOUT = 15;

  logic        byte_clk = 1'b0;
  logic        byte_rst;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic        cl_hs_req, cl_hs_rdy, cl_idle, cl_enable;
  logic        dl_hs_req, dl_hs_rdy, dl_idle;
  logic [31:0] out_data;
  logic        out_valid, busy, err, err_clr;
  logic [15:0] burst_cnt;

  always #5 byte_clk = ~byte_clk;

  dsi_link_sched #(.LP_GAP(LP_GAP), .TIMEOUT(TIMEOUT)) dut (
    .byte_clk (byte_clk),
    .byte_rst (byte_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .cl_hs_req(cl_hs_req),
    .cl_hs_rdy(cl_hs_rdy),
    .cl_idle  (cl_idle),
    .cl_enable(cl_enable),
    .dl_hs_req(dl_hs_req),
    .dl_hs_rdy(dl_hs_rdy),
    .dl_idle  (dl_idle),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr),
    .burst_cnt(burst_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Lane models: respond 2 cycles after the request changes
  int cl_on = 0, cl_off = 100, dl_on = 0, dl_off = 100;
  bit dl_manual = 1'b0;

  bit xfer = 1'b0;
  bit track = 1'b0;
  int gap_run = 0, last_gap_run = 0, idle_run = 0, last_idle_run = 0;
  int bursts_model = 0;
  logic [31:0] exp_q[$];
  int cls_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Coarse phase seen from the pins: 0 idle, 1 clk up, 2 data up, 3 stream,
  // 4 data down, 5 clk down or gap, 7 error
  function automatic int classify();
    if (!busy)                  return 0;
    if (err)                    return 7;
    if (in_ready)               return 3;
    if (cl_hs_req && dl_hs_req) return 2;
    if (cl_hs_req && cl_enable) return 4;
    if (cl_hs_req)              return 1;
    return 5;
  endfunction

  task automatic tick();
    logic [31:0] e;
    int c;
    #1;
    xfer = in_valid && in_ready;
    if (out_valid) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
      chk("out_data", out_data, e);
      chk("cl_enable_with_word", {31'd0, cl_enable}, 32'd1);
    end
    @(posedge byte_clk);
    #1;
    if (cl_hs_req) begin cl_on = (cl_on < 100) ? cl_on + 1 : cl_on; cl_off = 0; end
    else begin cl_off = (cl_off < 100) ? cl_off + 1 : cl_off; cl_on = 0; end
    if (dl_hs_req) begin dl_on = (dl_on < 100) ? dl_on + 1 : dl_on; dl_off = 0; end
    else begin dl_off = (dl_off < 100) ? dl_off + 1 : dl_off; dl_on = 0; end
    cl_hs_rdy = (cl_on >= 2);
    cl_idle   = (cl_off >= 2);
    if (!dl_manual) dl_hs_rdy = (dl_on >= 2);
    dl_idle   = (dl_off >= 2);
    // LP-side run: the CLK_DOWN cycle that sees cl_idle, then the gap
    if (busy && cl_idle && !cl_hs_req && !err) gap_run++;
    else if (gap_run > 0) begin last_gap_run = gap_run; gap_run = 0; end
    if (!busy) idle_run++;
    else if (idle_run > 0) begin last_idle_run = idle_run; idle_run = 0; end
    if (track) begin
      c = classify();
      if (cls_q.size() == 0 || cls_q[cls_q.size()-1] != c) cls_q.push_back(c);
    end
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_cl_hs_req"}, {31'd0, cl_hs_req}, 32'd0);
    chk({pfx, "_dl_hs_req"}, {31'd0, dl_hs_req}, 32'd0);
    chk({pfx, "_cl_enable"}, {31'd0, cl_enable}, 32'd0);
    chk({pfx, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({pfx, "_out_data"},  out_data,           32'd0);
    chk({pfx, "_busy"},      {31'd0, busy},      32'd0);
    chk({pfx, "_err"},       {31'd0, err},       32'd0);
    chk({pfx, "_burst_cnt"}, {16'd0, burst_cnt}, 32'd0);
  endtask

  task automatic send_burst(input int n, input int stall_at, input int stall_len,
                            input bit rand_stall, input bit hold);
    logic [31:0] w[$];
    int idx, guard, stalled;
    bit v;
    idx = 0; guard = 0; stalled = 0;
    for (int i = 0; i < n; i++) begin
      w.push_back($urandom);
      exp_q.push_back(w[i]);
    end
    while (idx < n && guard < 1000) begin
      v = 1'b1;
      if (in_ready && idx == stall_at && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else if (in_ready && rand_stall && $urandom_range(0, 3) == 0) begin
        v = 1'b0;
      end
      in_valid = v;
      in_data  = w[idx];
      in_last  = (idx == n - 1);
      if (in_ready && !v && stall_len > 0) begin
        #1;
        chk("stall_cl_enable", {31'd0, cl_enable}, 32'd1);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_dl_hs_req", {31'd0, dl_hs_req}, 32'd1);
      end
      tick();
      if (xfer) idx++;
      guard++;
    end
    chk("burst_words_sent", idx, n);
    if (stall_len > 0) chk("stall_cycles", stalled, stall_len);
    bursts_model++;
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 500) begin tick(); g++; end
    chk("idle_reached", {31'd0, busy}, 32'd0);
    chk("burst_cnt", {16'd0, burst_cnt}, 32'(bursts_model % 65536));
    chk("words_outstanding", exp_q.size(), 32'd0);
  endtask

  initial begin
    int g, n;
    logic [31:0] w;
    int exp_cls[$];

    byte_rst = 1'b1;
    in_data = 32'h0; in_valid = 1'b0; in_last = 1'b0;
    cl_hs_rdy = 1'b0; cl_idle = 1'b1; dl_hs_rdy = 1'b0; dl_idle = 1'b1;
    err_clr = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    byte_rst = 1'b0;
    tick();

    // err_clr outside ERR does nothing
    err_clr = 1'b1;
    tick();
    chk("clr_idle_err",  {31'd0, err},  32'd0);
    chk("clr_idle_busy", {31'd0, busy}, 32'd0);
    err_clr = 1'b0;
    tick();

    // Single 3-word burst, phase order from the pins
    cls_q.delete();
    cls_q.push_back(classify());
    track = 1'b1;
    send_burst(3, -1, 0, 1'b0, 1'b0);
    wait_idle();
    track = 1'b0;
    exp_cls = '{0, 1, 2, 3, 4, 5, 0};
    chk("phase_count", cls_q.size(), exp_cls.size());
    for (int i = 0; i < exp_cls.size() && i < cls_q.size(); i++)
      chk($sformatf("phase_%0d", i), cls_q[i], exp_cls[i]);
    chk("gap_len_single", last_gap_run, LP_GAP + 1);

    // Back-to-back with in_valid held through the gap
    send_burst(4, -1, 0, 1'b0, 1'b1);
    send_burst(2, -1, 0, 1'b0, 1'b0);
    chk("gap_len_b2b",  last_gap_run,  LP_GAP + 1);
    chk("idle_len_b2b", last_idle_run, 1);
    wait_idle();

    // Five-cycle source stall mid-burst
    send_burst(6, 3, 5, 1'b0, 1'b0);
    wait_idle();

    // Randomized bursts with random stalls and holds
    for (int b = 0; b < 6; b++)
      send_burst($urandom_range(1, 8), -1, 0, 1'b1,
                 (b < 5) ? bit'($urandom_range(0, 1)) : 1'b0);
    wait_idle();

    // Data lanes never ready: timeout into ERR
    dl_manual = 1'b1;
    dl_hs_rdy = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_data = $urandom;
    g = 0;
    while (!dl_hs_req && g < 100) begin tick(); g++; end
    chk("to_dl_req_rise", {31'd0, dl_hs_req}, 32'd1);
    n = 0;
    while (!err && n < 100) begin tick(); n++; end
    chk("timeout_cycles", n, TIMEOUT + 1);
    chk("err_set",       {31'd0, err},       32'd1);
    chk("err_cl_hs_req", {31'd0, cl_hs_req}, 32'd0);
    chk("err_dl_hs_req", {31'd0, dl_hs_req}, 32'd0);
    chk("err_cl_enable", {31'd0, cl_enable}, 32'd0);
    chk("err_in_ready",  {31'd0, in_ready},  32'd0);
    chk("err_busy",      {31'd0, busy},      32'd1);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) tick();
    chk("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    g = 0;
    while (err && g < 20) begin tick(); g++; end
    chk("err_cleared", {31'd0, err}, 32'd0);
    chk("err_to_gap_busy", {31'd0, busy}, 32'd1);
    err_clr = 1'b0;
    wait_idle();

    // Data-lane ready arrives on the last allowed wait cycle
    w = $urandom;
    exp_q.push_back(w);
    in_valid = 1'b1; in_last = 1'b1; in_data = w;
    g = 0;
    while (!dl_hs_req && g < 100) begin tick(); g++; end
    chk("edge_dl_req_rise", {31'd0, dl_hs_req}, 32'd1);
    repeat (TIMEOUT) tick();
    chk("edge_err_before", {31'd0, err}, 32'd0);
    dl_hs_rdy = 1'b1;
    tick();
    chk("edge_stream", {31'd0, in_ready}, 32'd1);
    chk("edge_err_after", {31'd0, err}, 32'd0);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    dl_hs_rdy = 1'b0; dl_manual = 1'b0;
    bursts_model++;
    wait_idle();

    // Reset pulse mid-stream
    w = $urandom;
    exp_q.push_back(w);
    in_valid = 1'b1; in_last = 1'b0; in_data = w;
    g = 0;
    while (!in_ready && g < 100) begin tick(); g++; end
    chk("rst_stream_reached", {31'd0, in_ready}, 32'd1);
    tick();
    in_data = $urandom | 32'h1;
    #2;
    byte_rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    byte_rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    bursts_model = 0;
    tick();
    send_burst(4, -1, 0, 1'b0, 1'b0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
